// File: rtl/regfile_mp.sv
// Multi-port register file with registered reads, optional r0-hardwired zero and write-to-read bypass.
// Reads take 1 cycle; no backpressure: every enabled read/write/reserve is accepted in the cycle it is presented.
module regfile_mp #(
  parameter  int DW       = 32,
  parameter  int DEPTH    = 32,
  parameter  int NREAD    = 4,
  parameter  int NWRITE   = 2,
  parameter  int ZERO_REG = 1,
  parameter  int BYPASS   = 1,
  localparam int AW       = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREAD-1:0]     ren,
  input  logic [NREAD*AW-1:0]  raddr,
  output logic [NREAD*DW-1:0]  rdata,
  output logic [NREAD-1:0]     rvalid,
  output logic [NREAD-1:0]     rbusy,
  input  logic [NWRITE-1:0]    wen,
  input  logic [NWRITE*AW-1:0] waddr,
  input  logic [NWRITE*DW-1:0] wdata,
  input  logic                 rsv_en,
  input  logic [AW-1:0]        rsv_addr
);

  logic [DW-1:0]    r_mem [DEPTH];
  logic [DEPTH-1:0] r_busy;
  logic [DEPTH-1:0] w_busy_nxt;
  logic [NREAD-1:0] w_hit;
  logic [NREAD-1:0] w_rzero;
  logic [DW-1:0]    w_byp_dat [NREAD];

  // Writes clear busy, then a same-cycle reserve re-marks it: the reserve is the newer producer.
  always_comb begin
    w_busy_nxt = r_busy;
    for (int j = 0; j < NWRITE; j++) begin
      if (wen[j]) w_busy_nxt[waddr[j*AW +: AW]] = 1'b0;
    end
    if (rsv_en) w_busy_nxt[rsv_addr] = 1'b1;
    if (ZERO_REG != 0) w_busy_nxt[0] = 1'b0;
  end

  // Ascending scan so the highest-index matching write port is the one forwarded.
  always_comb begin
    for (int i = 0; i < NREAD; i++) begin
      w_hit[i]     = 1'b0;
      w_byp_dat[i] = '0;
      w_rzero[i]   = (ZERO_REG != 0) && (raddr[i*AW +: AW] == '0);
      for (int j = 0; j < NWRITE; j++) begin
        if (wen[j] && (waddr[j*AW +: AW] == raddr[i*AW +: AW])) begin
          w_hit[i]     = 1'b1;
          w_byp_dat[i] = wdata[j*DW +: DW];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++) r_mem[k] <= '0;
    end else begin
      for (int j = 0; j < NWRITE; j++) begin
        if (wen[j] && !((ZERO_REG != 0) && (waddr[j*AW +: AW] == '0)))
          r_mem[waddr[j*AW +: AW]] <= wdata[j*DW +: DW];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_busy <= '0;
    else        r_busy <= w_busy_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata  <= '0;
      rvalid <= '0;
      rbusy  <= '0;
    end else begin
      rvalid <= ren;
      for (int i = 0; i < NREAD; i++) begin
        if (ren[i]) begin
          if (w_rzero[i])
            rdata[i*DW +: DW] <= '0;
          else if ((BYPASS != 0) && w_hit[i])
            rdata[i*DW +: DW] <= w_byp_dat[i];
          else
            rdata[i*DW +: DW] <= r_mem[raddr[i*AW +: AW]];
          if (w_rzero[i])
            rbusy[i] <= 1'b0;
          else if ((BYPASS != 0) && w_hit[i])
            rbusy[i] <= w_busy_nxt[raddr[i*AW +: AW]];
          else
            rbusy[i] <= r_busy[raddr[i*AW +: AW]];
        end
      end
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench: default, no-zero/no-bypass and wide soak configurations of regfile_mp.
module tb_regfile_mp;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // dut0 (ZERO_REG=1, BYPASS=1) and dut1 (ZERO_REG=0, BYPASS=0) share stimulus
  logic [3:0]   ren_a;
  logic [19:0]  raddr_a;
  logic [1:0]   wen_a;
  logic [9:0]   waddr_a;
  logic [63:0]  wdata_a;
  logic         rsv_en_a;
  logic [4:0]   rsv_addr_a;
  logic [127:0] rdata0, rdata1;
  logic [3:0]   rvalid0, rvalid1, rbusy0, rbusy1;

  logic [1:0]   ren_b;
  logic [7:0]   raddr_b;
  logic [2:0]   wen_b;
  logic [11:0]  waddr_b;
  logic [191:0] wdata_b;
  logic         rsv_en_b;
  logic [3:0]   rsv_addr_b;
  logic [127:0] rdata2;
  logic [1:0]   rvalid2, rbusy2;

  regfile_mp dut0 (
    .clk(clk), .rst_n(rst_n), .ren(ren_a), .raddr(raddr_a), .rdata(rdata0),
    .rvalid(rvalid0), .rbusy(rbusy0), .wen(wen_a), .waddr(waddr_a), .wdata(wdata_a),
    .rsv_en(rsv_en_a), .rsv_addr(rsv_addr_a));

  regfile_mp #(.ZERO_REG(0), .BYPASS(0)) dut1 (
    .clk(clk), .rst_n(rst_n), .ren(ren_a), .raddr(raddr_a), .rdata(rdata1),
    .rvalid(rvalid1), .rbusy(rbusy1), .wen(wen_a), .waddr(waddr_a), .wdata(wdata_a),
    .rsv_en(rsv_en_a), .rsv_addr(rsv_addr_a));

  regfile_mp #(.DW(64), .DEPTH(16), .NREAD(2), .NWRITE(3)) dut2 (
    .clk(clk), .rst_n(rst_n), .ren(ren_b), .raddr(raddr_b), .rdata(rdata2),
    .rvalid(rvalid2), .rbusy(rbusy2), .wen(wen_b), .waddr(waddr_b), .wdata(wdata_b),
    .rsv_en(rsv_en_b), .rsv_addr(rsv_addr_b));

  typedef struct {
    string       tag;
    int          dut;
    int          port;
    logic [63:0] dat;
    logic        bsy;
    logic        vld;
  } exp_t;

  exp_t exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  logic [63:0] m_mem [16];
  logic [15:0] m_busy;
  logic [63:0] m_last_d [2];
  logic        m_last_b [2];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic ex(input string tag, input int dut, input int port,
                    input logic [63:0] dat, input logic bsy, input logic vld);
    exp_t e;
    e.tag = tag; e.dut = dut; e.port = port; e.dat = dat; e.bsy = bsy; e.vld = vld;
    exp_q.push_back(e);
  endtask

  task automatic ex2(input string tag, input int port, input logic [63:0] dat,
                     input logic bsy, input logic vld);
    ex(tag, 0, port, dat, bsy, vld);
    ex(tag, 1, port, dat, bsy, vld);
  endtask

  task automatic drain();
    exp_t e;
    logic [63:0] od;
    logic ob, ov;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      case (e.dut)
        0:       begin od = {32'b0, rdata0[e.port*32 +: 32]}; ob = rbusy0[e.port]; ov = rvalid0[e.port]; end
        1:       begin od = {32'b0, rdata1[e.port*32 +: 32]}; ob = rbusy1[e.port]; ov = rvalid1[e.port]; end
        default: begin od = rdata2[e.port*64 +: 64];          ob = rbusy2[e.port]; ov = rvalid2[e.port]; end
      endcase
      chk($sformatf("%s d%0d p%0d rdata", e.tag, e.dut, e.port), od, e.dat);
      chk($sformatf("%s d%0d p%0d rbusy", e.tag, e.dut, e.port), {63'b0, ob}, {63'b0, e.bsy});
      chk($sformatf("%s d%0d p%0d rvalid", e.tag, e.dut, e.port), {63'b0, ov}, {63'b0, e.vld});
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    drain();
  endtask

  task automatic idle();
    ren_a = '0; raddr_a = '0; wen_a = '0; waddr_a = '0; wdata_a = '0;
    rsv_en_a = 1'b0; rsv_addr_a = '0;
  endtask

  task automatic rd(input int p, input logic [4:0] a);
    ren_a[p] = 1'b1;
    raddr_a[p*5 +: 5] = a;
  endtask

  task automatic wr(input int j, input logic [4:0] a, input logic [31:0] d);
    wen_a[j] = 1'b1;
    waddr_a[j*5 +: 5] = a;
    wdata_a[j*32 +: 32] = d;
  endtask

  task automatic rsv(input logic [4:0] a);
    rsv_en_a = 1'b1;
    rsv_addr_a = a;
  endtask

  // Reference model for the wide soak config (ZERO_REG=1, BYPASS=1).
  task automatic soak_cycle();
    logic [3:0]  a;
    logic [63:0] d;
    logic        b, hit;
    ren_b = 2'($urandom);
    wen_b = 3'($urandom);
    rsv_en_b = 1'($urandom);
    rsv_addr_b = 4'($urandom);
    for (int p = 0; p < 2; p++) raddr_b[p*4 +: 4] = 4'($urandom);
    for (int j = 0; j < 3; j++) begin
      waddr_b[j*4 +: 4] = 4'($urandom);
      wdata_b[j*64 +: 64] = {$urandom, $urandom};
    end
    for (int p = 0; p < 2; p++) begin
      if (ren_b[p]) begin
        a = raddr_b[p*4 +: 4];
        d = m_mem[a];
        hit = 1'b0;
        for (int j = 0; j < 3; j++) begin
          if (wen_b[j] && waddr_b[j*4 +: 4] == a) begin
            hit = 1'b1;
            d = wdata_b[j*64 +: 64];
          end
        end
        b = hit ? (rsv_en_b && rsv_addr_b == a) : m_busy[a];
        if (a == 4'd0) begin d = '0; b = 1'b0; end
        m_last_d[p] = d;
        m_last_b[p] = b;
      end
      ex("soak", 2, p, m_last_d[p], m_last_b[p], ren_b[p]);
    end
    for (int j = 0; j < 3; j++) begin
      a = waddr_b[j*4 +: 4];
      if (wen_b[j] && a != 4'd0) m_mem[a] = wdata_b[j*64 +: 64];
      if (wen_b[j]) m_busy[a] = 1'b0;
    end
    if (rsv_en_b && rsv_addr_b != 4'd0) m_busy[rsv_addr_b] = 1'b1;
    step();
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    ren_b = '0; raddr_b = '0; wen_b = '0; waddr_b = '0; wdata_b = '0;
    rsv_en_b = 1'b0; rsv_addr_b = '0;
    #12;
    for (int p = 0; p < 4; p++) chk("rst0 rdata", {32'b0, rdata0[p*32 +: 32]}, 64'd0);
    chk("rst0 rvalid", {60'b0, rvalid0}, 64'd0);
    chk("rst0 rbusy", {60'b0, rbusy0}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // reset: populate r5 busy+data, then async reset mid-cycle
    wr(0, 5'd5, 32'hDEAD_BEEF); rsv(5'd5);
    step();
    idle(); rd(0, 5'd5); ex2("pre_rst", 0, 64'hDEAD_BEEF, 1'b1, 1'b1);
    step();
    rst_n = 1'b0;
    #1;
    chk("async rst rdata", {32'b0, rdata0[31:0]}, 64'd0);
    chk("async rst rvalid", {63'b0, rvalid0[0]}, 64'd0);
    chk("async rst rbusy", {63'b0, rbusy0[0]}, 64'd0);
    chk("async rst rdata d1", {32'b0, rdata1[31:0]}, 64'd0);
    #3;
    rst_n = 1'b1;
    ex2("post_rst", 0, 64'h0, 1'b0, 1'b1);
    step();

    // basic read and hold
    idle(); wr(0, 5'd7, 32'h1234_5678);
    step();
    idle(); rd(0, 5'd7); ex2("basic", 0, 64'h1234_5678, 1'b0, 1'b1);
    step();
    idle(); ex2("hold", 0, 64'h1234_5678, 1'b0, 1'b0);
    step();

    // zero register
    idle(); wr(0, 5'd0, 32'hFFFF_FFFF); rsv(5'd0);
    step();
    idle();
    for (int p = 0; p < 4; p++) begin
      rd(p, 5'd0);
      ex("zero", 0, p, 64'h0, 1'b0, 1'b1);
      ex("zero", 1, p, 64'hFFFF_FFFF, 1'b1, 1'b1);
    end
    step();

    // bypass and collision
    idle(); wr(0, 5'd3, 32'h0BAD_F00D);
    step();
    idle(); wr(0, 5'd3, 32'hAAAA_AAAA); wr(1, 5'd3, 32'h5555_5555); rd(2, 5'd3);
    ex("collide", 0, 2, 64'h5555_5555, 1'b0, 1'b1);
    ex("collide", 1, 2, 64'h0BAD_F00D, 1'b0, 1'b1);
    step();
    idle(); rd(2, 5'd3); ex2("after_collide", 2, 64'h5555_5555, 1'b0, 1'b1);
    step();
    idle(); wr(0, 5'd0, 32'h0000_1234); rd(1, 5'd0);
    ex("byp_zero", 0, 1, 64'h0, 1'b0, 1'b1);
    ex("byp_zero", 1, 1, 64'hFFFF_FFFF, 1'b1, 1'b1);
    step();

    // scoreboard
    idle(); rsv(5'd9);
    step();
    idle(); rd(0, 5'd9); ex2("sb_rsv", 0, 64'h0, 1'b1, 1'b1);
    step();
    idle(); wr(0, 5'd9, 32'h99); rd(1, 5'd9);
    ex("sb_wr_byp", 0, 1, 64'h99, 1'b0, 1'b1);
    ex("sb_wr_byp", 1, 1, 64'h0, 1'b1, 1'b1);
    step();
    idle(); rd(0, 5'd9); ex2("sb_clr", 0, 64'h99, 1'b0, 1'b1);
    step();
    idle(); rsv(5'd9); wr(1, 5'd9, 32'h77); rd(3, 5'd9);
    ex("sb_rsv_wr", 0, 3, 64'h77, 1'b1, 1'b1);
    ex("sb_rsv_wr", 1, 3, 64'h99, 1'b0, 1'b1);
    step();
    idle(); rd(0, 5'd9); ex2("sb_rsv_wins", 0, 64'h77, 1'b1, 1'b1);
    step();
    idle(); rsv(5'd9); rd(0, 5'd9); ex2("sb_rsv_again", 0, 64'h77, 1'b1, 1'b1);
    step();
    idle(); rd(0, 5'd9); ex2("sb_still_busy", 0, 64'h77, 1'b1, 1'b1);
    step();
    idle();

    // random soak on the wide config; it has seen only idle inputs since the reset pulse
    for (int k = 0; k < 16; k++) m_mem[k] = '0;
    m_busy = '0;
    for (int p = 0; p < 2; p++) begin m_last_d[p] = '0; m_last_b[p] = 1'b0; end
    for (int c = 0; c < 10000; c++) soak_cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
Parametrised multi-port integer register file for the next core generation. It provides NREAD synchronous read ports and NWRITE write ports, with optional hardwired zero register and optional same-cycle write-to-read bypass. A per-register busy scoreboard lets issue logic reserve a destination and see a pending-write flag on every read. It sits between decode/issue (read and reserve side) and writeback (write side).

Parameters:
DW, 32, data width in bits
DEPTH, 32, number of registers; power of two, >= 2
NREAD, 4, number of read ports
NWRITE, 2, number of write ports
ZERO_REG, 1, 1 = register 0 reads as 0, ignores writes, never busy
BYPASS, 1, 1 = same-cycle write data forwarded to a read of the same address
AW (localparam), $clog2(DEPTH), address width

Ports:
clk  in  1  clock, all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
ren  in  NREAD  per-port read enable
raddr  in  NREAD*AW  read addresses; port i at [i*AW +: AW]
rdata  out  NREAD*DW  registered read data; port i at [i*DW +: DW]
rvalid  out  NREAD  registered copy of ren
rbusy  out  NREAD  registered busy flag of the addressed register
wen  in  NWRITE  per-port write enable
waddr  in  NWRITE*AW  write addresses
wdata  in  NWRITE*DW  write data
rsv_en  in  1  reserve request: mark rsv_addr busy
rsv_addr  in  AW  register to reserve

Behaviour:
- Reset (rst_n low, asynchronous): all registers, rdata, rvalid, rbusy and busy bits go to 0 immediately and hold until rst_n rises. The first rising edge with rst_n high is a normal operating cycle.
- Read latency is 1 cycle. With ren[i]=1 at edge N, rdata[i], rbusy[i] and rvalid[i]=1 are valid after edge N.
- With ren[i]=0, rdata[i] and rbusy[i] hold their previous values and rvalid[i]=0. Outputs are never driven to Z.
- Write: for each port j with wen[j]=1, register waddr[j] takes wdata[j] at the edge.
- Write collision: if several write ports target the same address in one cycle, the highest-index port wins.
- Bypass:
  - BYPASS=1: a read whose raddr matches an active write in the same cycle returns the winning wdata, and rbusy reflects post-edge busy.
  - BYPASS=0: the read returns the pre-edge contents and pre-edge busy.
- ZERO_REG=1, address 0:
  - writes are discarded;
  - reads return 0 and rbusy=0, including under bypass;
  - reservation is ignored.
- Scoreboard:
  - busy[a] is set by rsv_en with rsv_addr=a.
  - busy[a] is cleared by any enabled write to address a.
  - Reserve and write to the same address in one cycle: reserve wins, so busy stays/becomes 1 (a newer producer was issued).
  - Reserving an already busy register: busy stays 1, no error.
- Address out of range is not possible (DEPTH is a power of two).
- All NREAD ports are independent. Any combination of identical addresses is legal.

Test Plan:
- Reset: write 0xDEAD_BEEF to r5, then pulse rst_n low mid-cycle -> rdata/rvalid/rbusy go 0 immediately; after release, read r5 -> 0x0000_0000.
- Basic and hold: write r7=0x1234_5678, next cycle ren[0]=1 raddr=7 -> rdata[0]=0x1234_5678 and rvalid[0]=1 one edge later; drop ren[0] -> rdata[0] holds, rvalid[0]=0.
- Zero register: write r0=0xFFFF_FFFF, then read r0 on all four ports -> 0 with rbusy=0; repeat with ZERO_REG=0 -> 0xFFFF_FFFF.
- Bypass and collision: in one cycle, wen=2'b11 both to r3 with wdata0=0xAAAA_AAAA, wdata1=0x5555_5555, plus ren[2] raddr=3 -> BYPASS=1 returns 0x5555_5555; BYPASS=0 returns the old value; r3 afterwards = 0x5555_5555.
- Scoreboard: reserve r9, then read r9 -> rbusy=1; write r9 -> next read rbusy=0; reserve and write r9 in the same cycle -> rbusy=1 afterwards.
- Random soak: 10k cycles of random ren/wen/rsv against a reference model, with NREAD=2, NWRITE=3, DEPTH=16, DW=64 -> zero mismatches.
